elem_rotate_seq: RTL and testbench
==================================

# elem_rotate_seq

Element-rotation sequencer for the DAC digital selector. It accepts a thermometer-count request (how many of the 6 unit elements to fire) and issues one element index per clock on a 3-bit select plus enable, walking a rotating pointer modulo 6 so consecutive requests spread usage across elements (data-weighted averaging). It sits directly upstream of the 3→6 one-hot element decoder and drives that decoder's select/enable inputs.

## Interface
- NUM_ELEM, 6, number of unit elements; pointer wraps at NUM_ELEM-1
- IDX_W, 3, width of element index
- CODE_W, 3, width of request count
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- code_valid  in  1  request present
- code_ready  out  1  sequencer can accept a request
- code  in  CODE_W  number of elements to fire, legal 0..6
- sel_hold  in  1  stall issue; freezes pointer and remaining count
- sel_s  out  IDX_W  element index to decoder (registered)
- sel_en  out  1  decoder enable (registered)
- done  out  1  one-cycle pulse, request fully issued
- code_err  out  1  one-cycle pulse, request code was 7 (clamped)
- ptr  out  IDX_W  current rotation pointer (next element to issue)

## Operation
- States: IDLE, ISSUE.
- code_ready = (state == IDLE). Transfer = code_valid && code_ready at a rising edge.
- IDLE, transfer with code = 0: stay IDLE, done = 1 next cycle, no sel_en.
- IDLE, transfer with code 1..6: remaining := code; go ISSUE; sel_en := 1, sel_s := ptr, ptr := ptr+1 mod 6, remaining decremented by 1.
- IDLE, transfer with code = 7: treated as 6; code_err = 1 next cycle.
- ISSUE, sel_hold = 0, remaining > 0: sel_en := 1, sel_s := ptr, ptr advances mod 6, remaining decremented by 1.
- ISSUE, sel_hold = 1: sel_en := 0, sel_s holds, ptr and remaining hold.
- ISSUE, remaining = 0 after the last issue: the next edge goes IDLE, sel_en := 0.
- done asserts in the same cycle the last sel_en = 1 is presented.
- ptr wraps 5→0. It is never reset between requests; only rst clears it.
- sel_s is always in 0..5 whenever sel_en = 1.

## Timing
- Reset values (edge with rst = 1): state IDLE, ptr 0, remaining 0, sel_s 0, sel_en 0, done 0, code_err 0, code_ready 1 in the following cycle.
- Request of N≥1 accepted at edge E with no holds:
  - sel_en = 1 in the N cycles following edges E..E+N-1.
  - done is high in the cycle after edge E+N-1.
  - code_ready returns high after edge E+N.
  - The next request is accepted no earlier than edge E+N.
- Each sel_hold cycle extends the issue window by exactly one cycle.
- rst mid-ISSUE discards the pending count, returns to IDLE, and zeroes ptr and all outputs on that edge.
- rst has priority over transfer and sel_hold.

## Structure
- Shared package dac_sel_pkg holds:
  - NUM_ELEM, IDX_W, CODE_W
  - the state enum {IDLE, ISSUE}
  - the clamp constant MAX_CODE = 6
- Sub-module elem_ptr_wrap: modulo-NUM_ELEM pointer register with advance and clear inputs; instantiated once.
- The top level holds the FSM, the remaining counter and the output registers.

## Test plan
- Reset, then code = 3 with valid held high: sel_s sequence 0,1,2 with sel_en = 1; done in the third cycle; ptr = 3; ready high afterwards.
- Two requests, 4 then 4: sel_s 0,1,2,3 then 4,5,0,1 (wrap); final ptr = 2.
- code = 0: no sel_en; done pulses once one cycle after acceptance; ptr unchanged.
- code = 7: six issues, sel_s ptr..ptr+5 mod 6; code_err pulses once; done on the sixth issue.
- code = 5 with sel_hold high for 2 cycles after the second issue: sel_en gaps of 2; indices stay contiguous; done delayed by 2 cycles.
- rst asserted during the third issue of code = 6: next cycle sel_en = 0, ptr = 0, code_ready = 1; the following code = 2 issues 0,1.

Source files
------------

// File: rtl/dac_sel_pkg.sv
// rtl/dac_sel_pkg.sv - shared constants and state type for the DAC element selector
package dac_sel_pkg;

    localparam int NUM_ELEM = 6;
    localparam int IDX_W    = 3;
    localparam int CODE_W   = 3;

    // Requests above this count are clamped to it and flagged
    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(6);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/elem_ptr_wrap.sv
// rtl/elem_ptr_wrap.sv - modulo-NUM_ELEM rotation pointer with advance and clear
module elem_ptr_wrap
    import dac_sel_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [IDX_W-1:0] o_ptr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    logic [IDX_W-1:0] r_ptr;

    // Pointer register: clear wins, otherwise step and wrap from the last element to 0
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/elem_rotate_seq.sv
// rtl/elem_rotate_seq.sv - rotating element-issue sequencer driving the one-hot element decoder
module elem_rotate_seq
    import dac_sel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code,
    input  logic              sel_hold,
    output logic [IDX_W-1:0]  sel_s,
    output logic              sel_en,
    output logic              done,
    output logic              code_err,
    output logic [IDX_W-1:0]  ptr
);

    state_t            r_state;
    logic [CODE_W-1:0] r_rem;
    logic [IDX_W-1:0]  r_sel_s;
    logic              r_sel_en;
    logic              r_done;
    logic              r_code_err;

    state_t            w_state_nxt;
    logic [CODE_W-1:0] w_rem_nxt;
    logic [IDX_W-1:0]  w_sel_s_nxt;
    logic              w_sel_en_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_adv;
    logic              w_xfer;
    logic              w_code_over;
    logic [CODE_W-1:0] w_code_eff;
    logic [IDX_W-1:0]  w_ptr;

    elem_ptr_wrap u_ptr (
        .i_clk (clk),
        .i_clr (rst),
        .i_adv (w_adv),
        .o_ptr (w_ptr)
    );

    assign code_ready  = (r_state == IDLE);
    assign w_xfer      = code_valid && code_ready;
    assign w_code_over = (code > MAX_CODE);
    assign w_code_eff  = w_code_over ? MAX_CODE : code;

    // State and output registers; reset discards any pending count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_sel_s    <= '0;
            r_sel_en   <= 1'b0;
            r_done     <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_sel_s    <= w_sel_s_nxt;
            r_sel_en   <= w_sel_en_nxt;
            r_done     <= w_done_nxt;
            r_code_err <= w_err_nxt;
        end
    end

    // Next-state logic: each issue presents the pointer, advances it and consumes one count
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_sel_s_nxt  = r_sel_s;
        w_sel_en_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_err_nxt = w_code_over;
                    if (w_code_eff == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ISSUE;
                        w_sel_en_nxt = 1'b1;
                        w_sel_s_nxt  = w_ptr;
                        w_adv        = 1'b1;
                        w_rem_nxt    = w_code_eff - 1'b1;
                        w_done_nxt   = (w_code_eff == CODE_W'(1));
                    end
                end
            end
            ISSUE: begin
                // An exhausted count always retires, so hold cannot stretch the tail
                if (r_rem == '0) begin
                    w_state_nxt = IDLE;
                end else if (!sel_hold) begin
                    w_sel_en_nxt = 1'b1;
                    w_sel_s_nxt  = w_ptr;
                    w_adv        = 1'b1;
                    w_rem_nxt    = r_rem - 1'b1;
                    w_done_nxt   = (r_rem == CODE_W'(1));
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign sel_s    = r_sel_s;
    assign sel_en   = r_sel_en;
    assign done     = r_done;
    assign code_err = r_code_err;
    assign ptr      = w_ptr;

endmodule

// File: tb/tb_elem_rotate_seq.sv
// tb/tb_elem_rotate_seq.sv - table-driven self-checking bench for elem_rotate_seq
module tb_elem_rotate_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       code_valid;
    logic       code_ready;
    logic [2:0] code;
    logic       sel_hold;
    logic [2:0] sel_s;
    logic       sel_en;
    logic       done;
    logic       code_err;
    logic [2:0] ptr;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] code;
        logic       hold;
        logic       en;
        logic [2:0] s;
        logic       done;
        logic       err;
        logic       rdy;
        logic [2:0] ptr;
    } vec_t;

    vec_t vecs[$];

    elem_rotate_seq dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .sel_hold   (sel_hold),
        .sel_s      (sel_s),
        .sel_en     (sel_en),
        .done       (done),
        .code_err   (code_err),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic [2:0] c, input logic h,
                       input logic en, input logic [2:0] s, input logic d, input logic e,
                       input logic rdy, input logic [2:0] p);
        vec_t t;
        t.rst = r; t.v = v; t.code = c; t.hold = h;
        t.en = en; t.s = s; t.done = d; t.err = e; t.rdy = rdy; t.ptr = p;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    endtask

    initial begin
        int         exp_idx;
        int         n_en;
        logic       seen_done;

        //   rst v  code hold | en s  done err rdy ptr
        // reset
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        // code 3, valid held high
        add(0, 1, 3, 0,   1, 0, 0, 0, 0, 1);
        add(0, 1, 3, 0,   1, 1, 0, 0, 0, 2);
        add(0, 1, 3, 0,   1, 2, 1, 0, 0, 3);
        add(0, 1, 3, 0,   0, 2, 0, 0, 1, 3);
        add(0, 0, 0, 0,   0, 2, 0, 0, 1, 3);
        // reset, then 4 and 4 with wrap
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 1, 4, 0,   1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,   1, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0,   1, 2, 0, 0, 0, 3);
        add(0, 0, 0, 0,   1, 3, 1, 0, 0, 4);
        add(0, 1, 4, 0,   0, 3, 0, 0, 1, 4);
        add(0, 1, 4, 0,   1, 4, 0, 0, 0, 5);
        add(0, 0, 0, 0,   1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,   1, 1, 1, 0, 0, 2);
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 2);
        // code 0
        add(0, 1, 0, 0,   0, 1, 1, 0, 1, 2);
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 2);
        // code 7 clamps to 6
        add(0, 1, 7, 0,   1, 2, 0, 1, 0, 3);
        add(0, 0, 0, 0,   1, 3, 0, 0, 0, 4);
        add(0, 0, 0, 0,   1, 4, 0, 0, 0, 5);
        add(0, 0, 0, 0,   1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,   1, 1, 1, 0, 0, 2);
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 2);
        // code 5, two hold cycles after second issue
        add(0, 1, 5, 0,   1, 2, 0, 0, 0, 3);
        add(0, 0, 0, 0,   1, 3, 0, 0, 0, 4);
        add(0, 0, 0, 1,   0, 3, 0, 0, 0, 4);
        add(0, 0, 0, 1,   0, 3, 0, 0, 0, 4);
        add(0, 0, 0, 0,   1, 4, 0, 0, 0, 5);
        add(0, 0, 0, 0,   1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
        // code 6 aborted by reset during third issue, then code 2
        add(0, 1, 6, 0,   1, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0,   1, 2, 0, 0, 0, 3);
        add(0, 0, 0, 0,   1, 3, 0, 0, 0, 4);
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(0, 1, 2, 0,   1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0,   1, 1, 1, 0, 0, 2);
        add(0, 0, 0, 0,   0, 1, 0, 0, 1, 2);
        // reset beats a simultaneous transfer
        add(1, 1, 3, 0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 1, 0);

        rst = 1'b1; code_valid = 1'b0; code = '0; sel_hold = 1'b0;

        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            code_valid = vecs[i].v;
            code       = vecs[i].code;
            sel_hold   = vecs[i].hold;
            @(posedge clk);
            #1;
            chk("sel_en",     i, int'(sel_en),     int'(vecs[i].en));
            chk("sel_s",      i, int'(sel_s),      int'(vecs[i].s));
            chk("done",       i, int'(done),       int'(vecs[i].done));
            chk("code_err",   i, int'(code_err),   int'(vecs[i].err));
            chk("code_ready", i, int'(code_ready), int'(vecs[i].rdy));
            chk("ptr",        i, int'(ptr),        int'(vecs[i].ptr));
        end

        // Alternating hold during a full code-6 request: indices stay contiguous from ptr 0
        rst = 1'b0; code_valid = 1'b1; code = 3'd6; sel_hold = 1'b0;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        exp_idx    = 0;
        n_en       = 0;
        seen_done  = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sel_en) begin
                chk("hs_sel_s", cyc, int'(sel_s), exp_idx);
                exp_idx = (exp_idx + 1) % 6;
                n_en++;
            end
            if (done) begin
                chk("hs_done_with_en", cyc, int'(sel_en), 1);
                seen_done = 1'b1;
                break;
            end
            sel_hold = cyc[0];
            @(posedge clk);
            #1;
        end
        sel_hold = 1'b0;
        chk("hs_done_seen", 0, int'(seen_done), 1);
        chk("hs_issue_count", 0, n_en, 6);
        chk("hs_ptr_after", 0, int'(ptr), 0);
        @(posedge clk);
        #1;
        chk("hs_ready_after", 0, int'(code_ready), 1);
        chk("hs_en_after", 0, int'(sel_en), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
